iir_sample_sequencer: RTL and testbench

//  Sample-rate controller for the HLS IIR core (ap_ctrl_hs handshake). Generates a periodic sample tick,

---
 rtl/iir_sample_sequencer_pkg.sv | 26 ++
 rtl/iir_sample_sequencer_tick_gen.sv | 29 ++
 rtl/iir_sample_sequencer.sv | 120 ++++++++++++
 tb/tb_iir_sample_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_sample_sequencer_pkg.sv
// Shared types for the IIR sample sequencer: stimulus modes, FSM states and
// the overrun counter width.
package iir_seq_pkg;

  typedef enum logic [1:0] {
    IMPULSE  = 2'd0,
    STEP     = 2'd1,
    EXTERNAL = 2'd2,
    ZERO     = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned OVR_W = 16;

  // Saturating increment used by the overrun counter.
  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/iir_sample_sequencer_tick_gen.sv
// Sample-rate tick generator: one tick every period+1 clocks while enabled.
module iir_tick_gen #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic                wrap;

  // >= rather than == so a period shortened mid-count wraps at once.
  assign wrap = (cnt >= period);
  assign tick = enable && wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iir_sample_sequencer.sv
// Sample-rate controller for the HLS IIR core: issues one ap_ctrl_hs
// transaction per tick and captures ap_return into y with a valid strobe.
module iir_sample_sequencer
  import iir_seq_pkg::*;
#(
  parameter int unsigned   DW       = 20,
  parameter int unsigned   PERIOD_W = 16,
  parameter int unsigned   BURST_W  = 10,
  parameter logic [DW-1:0] AMP      = DW'(20'h1_0000)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  mode_t               mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic [DW-1:0]       ext_x,
  output logic                ap_start,
  input  logic                ap_ready,
  input  logic                ap_done,
  input  logic                ap_idle,
  output logic [DW-1:0]       x,
  input  logic [DW-1:0]       ap_return,
  output logic [DW-1:0]       y,
  output logic                y_valid,
  output logic [OVR_W-1:0]    overrun_cnt,
  output logic                busy
);

  state_t             state;
  logic               tick;
  logic [BURST_W-1:0] samp_cnt;
  logic [BURST_W-1:0] next_samp;
  logic [DW-1:0]      sel_x;
  logic               status_unused;

  // ap_idle is informational only; the handshake is driven by ready/done.
  assign status_unused = ap_idle;

  iir_tick_gen #(
    .PERIOD_W(PERIOD_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .period(period),
    .tick  (tick)
  );

  always_comb begin
    sel_x     = '0;
    next_samp = samp_cnt;
    unique case (mode)
      IMPULSE: begin
        sel_x     = (samp_cnt == '0) ? AMP : '0;
        next_samp = (samp_cnt == '0) ? burst_len : samp_cnt - 1'b1;
      end
      STEP:     sel_x = AMP;
      EXTERNAL: sel_x = ext_x;
      default:  sel_x = '0;
    endcase
  end

  assign busy = (state == START) || (state == WAIT_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ap_start    <= 1'b0;
      x           <= '0;
      y           <= '0;
      y_valid     <= 1'b0;
      overrun_cnt <= '0;
      samp_cnt    <= '0;
    end else begin
      y_valid <= 1'b0;
      if (tick && (state == START || state == WAIT_DONE)) begin
        overrun_cnt <= sat_inc(overrun_cnt);
      end
      unique case (state)
        IDLE: begin
          samp_cnt <= '0;
          if (enable) state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick) begin
            x        <= sel_x;
            samp_cnt <= next_samp;
            ap_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          // A combinational core may finish in the same cycle it accepts.
          if (ap_ready) begin
            ap_start <= 1'b0;
            if (ap_done) begin
              y       <= ap_return;
              y_valid <= 1'b1;
              state   <= enable ? WAIT_TICK : IDLE;
            end else begin
              state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (ap_done) begin
            y       <= ap_return;
            y_valid <= 1'b1;
            state   <= enable ? WAIT_TICK : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_sample_sequencer.sv
// Bench for iir_sample_sequencer: directed scenarios plus a randomized phase,
// checked every cycle against an arithmetic reference of tick timing and sample selection.
module tb_iir_sample_sequencer;
  import iir_seq_pkg::*;

  localparam int unsigned   DW  = 20;
  localparam int unsigned   PW  = 16;
  localparam int unsigned   BW  = 10;
  localparam logic [DW-1:0] AMP = 20'h1_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  mode_t         mode = IMPULSE;
  logic [PW-1:0] period = '0;
  logic [BW-1:0] burst_len = '0;
  logic [DW-1:0] ext_x = '0;
  logic          ap_start;
  logic          ap_ready = 1'b0;
  logic          ap_done = 1'b0;
  logic          ap_idle = 1'b1;
  logic [DW-1:0] x;
  logic [DW-1:0] ap_return = '0;
  logic [DW-1:0] y;
  logic          y_valid;
  logic [15:0]   overrun_cnt;
  logic          busy;

  always #5 clk = ~clk;

  iir_sample_sequencer #(
    .DW      (DW),
    .PERIOD_W(PW),
    .BURST_W (BW),
    .AMP     (AMP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .period     (period),
    .burst_len  (burst_len),
    .ext_x      (ext_x),
    .ap_start   (ap_start),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .x          (x),
    .ap_return  (ap_return),
    .y          (y),
    .y_valid    (y_valid),
    .overrun_cnt(overrun_cnt),
    .busy       (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: ticks from cycle arithmetic, impulses from a sample index modulo burst_len+1.
  longint        cyc = 0;
  longint        e0 = 0;
  bit            en_prev, armed, outstanding, start_flag, exp_yv;
  int            k_imp, exp_ovr;
  logic [DW-1:0] exp_x, exp_y;

  // Core model: ready rl cycles and done dl cycles after the first START edge.
  bit            bfm_busy, noise, lat_rand, rand_ext;
  longint        t0;
  int            rl, dl, rl_fix, dl_fix;
  logic [DW-1:0] ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    en_prev = 0; armed = 0; outstanding = 0; start_flag = 0; exp_yv = 0;
    k_imp = 0; exp_ovr = 0; exp_x = '0; exp_y = '0;
    bfm_busy = 0; ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
  endtask

  function automatic bit tick_now();
    if (!enable) return 1'b0;
    return ((cyc - e0) % (longint'(period) + 1)) == longint'(period);
  endfunction

  task automatic model_edge();
    bit t, yv, done_now;
    if (enable && !en_prev) e0 = cyc;
    t  = tick_now();
    yv = 0;
    if (outstanding) begin
      if (t) exp_ovr = (exp_ovr == 65535) ? 65535 : exp_ovr + 1;
      done_now = start_flag ? (ap_ready && ap_done) : ap_done;
      if (start_flag && ap_ready) start_flag = 0;
      if (done_now) begin
        exp_y = ap_return; yv = 1; outstanding = 0; armed = enable;
      end
    end else if (!armed) begin
      k_imp = 0;
      armed = enable;
    end else if (!enable) begin
      armed = 0;
    end else if (t) begin
      case (mode)
        IMPULSE: begin
          exp_x = (k_imp % (int'(burst_len) + 1) == 0) ? AMP : '0;
          k_imp++;
        end
        STEP:     exp_x = AMP;
        EXTERNAL: exp_x = ext_x;
        default:  exp_x = '0;
      endcase
      outstanding = 1; start_flag = 1;
    end
    exp_yv  = yv;
    en_prev = enable;
    if (bfm_busy && cyc == t0 + dl) bfm_busy = 0;
  endtask

  task automatic check_outputs();
    chk("ap_start", ap_start, start_flag);
    chk("x", x, exp_x);
    chk("y", y, exp_y);
    chk("y_valid", y_valid, exp_yv);
    chk("overrun_cnt", overrun_cnt, exp_ovr);
    chk("busy", busy, outstanding);
  endtask

  task automatic drive_core();
    if (!bfm_busy && ap_start === 1'b1) begin
      bfm_busy = 1; t0 = cyc;
      if (lat_rand) begin
        rl = $urandom_range(0, 2); dl = rl + $urandom_range(0, 3);
      end else begin
        rl = rl_fix; dl = dl_fix;
      end
      ret = DW'($urandom);
    end
    if (bfm_busy) begin
      ap_ready  = (cyc == t0 + rl);
      ap_done   = (cyc == t0 + dl);
      ap_return = ap_done ? ret : DW'($urandom);
      ap_idle   = 1'b0;
    end else begin
      ap_ready  = noise && ($urandom_range(0, 3) == 0);
      ap_done   = noise && ($urandom_range(0, 3) == 0);
      ap_return = DW'($urandom);
      ap_idle   = 1'b1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
      cyc++;
      drive_core();
      if (rand_ext) ext_x = DW'($urandom);
    end
  endtask

  initial begin
    int found, pulses;
    reset_model();
    noise = 0; lat_rand = 0; rand_ext = 1; rl_fix = 0; dl_fix = 2;

    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Impulse train, burst_len=3, ticks every 4 clocks, done 2 clk after ready.
    period = 16'd3; burst_len = 10'd3; mode = IMPULSE; enable = 1'b1;
    step(40);
    enable = 1'b0; step(4);

    // Tick every cycle with a slow core: dropped ticks count as overruns.
    period = 16'd0; mode = STEP; rl_fix = 0; dl_fix = 3; enable = 1'b1;
    step(30);
    enable = 1'b0; step(6);

    // Combinational core: ready and done in the first START cycle.
    period = 16'd2; mode = EXTERNAL; rl_fix = 0; dl_fix = 0; enable = 1'b1;
    step(20);
    enable = 1'b0; step(4);

    // External sample held until ap_ready even when ext_x changes.
    period = 16'd4; rl_fix = 2; dl_fix = 3; rand_ext = 0; ext_x = 20'h0_ABCD;
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (start_flag) found = 1;
    end
    chk("reach_start_ext", found, 1);
    ext_x = 20'h1_2345;
    step(2);
    chk("x_hold", x, 20'h0_ABCD);
    rand_ext = 1;
    step(20);

    // enable drops while waiting for done: the result is still captured once.
    period = 16'd1; mode = STEP; rl_fix = 0; dl_fix = 4;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (outstanding && !start_flag) found = 1;
    end
    chk("reach_wait_done", found, 1);
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (y_valid === 1'b1) pulses++;
    end
    chk("yv_pulses_after_disable", pulses, 1);

    // Asynchronous reset while in START, then restart begins with an impulse.
    period = 16'd2; burst_len = 10'd2; mode = IMPULSE; rl_fix = 1; dl_fix = 2;
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (start_flag) found = 1;
    end
    chk("reach_start_rst", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ap_start", ap_start, 1'b0);
    chk("rst_x", x, '0);
    chk("rst_y", y, '0);
    chk("rst_y_valid", y_valid, 1'b0);
    chk("rst_overrun", overrun_cnt, '0);
    chk("rst_busy", busy, 1'b0);
    enable = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (start_flag) found = 1;
    end
    chk("restart_found", found, 1);
    chk("restart_impulse", x, AMP);
    step(20);

    // Randomized runs: latencies, modes, periods, spurious ready/done while idle.
    noise = 1; lat_rand = 1;
    repeat (12) begin
      enable = 1'b0;
      period = PW'($urandom_range(0, 5));
      burst_len = BW'($urandom_range(0, 4));
      step(1);
      enable = 1'b1;
      repeat (40) begin
        mode = mode_t'($urandom_range(0, 3));
        step(1);
      end
      enable = 1'b0;
      step($urandom_range(1, 8));
    end
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
